// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results and buffered load results share one register-file write port.
// ALU results have priority; a starvation counter forces a buffered load out when the ALU hogs the port.
`timescale 1ns/1ps
module wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alu_valid,
    input  logic [4:0]              alu_rd,
    input  logic [31:0]             alu_data,
    output logic                    alu_ready,
    input  logic                    ld_valid,
    input  logic [4:0]              ld_rd,
    input  logic [31:0]             ld_data,
    output logic                    ld_ready,
    output logic                    wen,
    output logic [4:0]              regWAddr,
    output logic [31:0]             regWData,
    output logic [31:0]             pend_mask,
    output logic [$clog2(DEPTH):0]  buf_count
);

    localparam int             AW   = $clog2(DEPTH);
    localparam int             SW   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]  SMAX = SW'(STARVE_MAX);
    localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);

    logic [4:0]    r_mem_rd   [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_count;
    logic [SW-1:0] r_starve;

    logic          w_empty, w_force, w_sel_ld, w_sel_alu, w_enq;
    logic [4:0]    w_rd;
    logic [31:0]   w_data;
    logic [AW-1:0] w_off;
    logic [31:0]   w_pend;

    assign w_empty   = (r_count == '0);
    assign w_force   = (r_starve == SMAX) && !w_empty;
    assign w_sel_ld  = w_force || (!alu_valid && !w_empty);
    assign w_sel_alu = !w_force && alu_valid;
    assign w_enq     = ld_valid && ld_ready;

    assign alu_ready = !w_force;
    assign ld_ready  = (r_count != FULL);
    assign buf_count = r_count;
    assign pend_mask = w_pend;

    assign w_rd   = w_sel_ld ? r_mem_rd[r_rp]   : alu_rd;
    assign w_data = w_sel_ld ? r_mem_data[r_rp] : alu_data;

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem_rd[r_wp]   <= ld_rd;
            r_mem_data[r_wp] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_count  <= '0;
            r_starve <= '0;
            wen      <= 1'b0;
            regWAddr <= '0;
            regWData <= '0;
        end else begin
            if (w_enq)    r_wp <= r_wp + 1'b1;
            if (w_sel_ld) r_rp <= r_rp + 1'b1;
            r_count <= r_count + (AW+1)'(w_enq) - (AW+1)'(w_sel_ld);

            if (w_sel_ld || w_empty)
                r_starve <= '0;
            else if (w_sel_alu && r_starve != SMAX)
                r_starve <= r_starve + 1'b1;

            // x0 writes are consumed but leave the visible write port untouched.
            if (w_sel_ld || w_sel_alu) begin
                wen <= (w_rd != 5'd0);
                if (w_rd != 5'd0) begin
                    regWAddr <= w_rd;
                    regWData <= w_data;
                end
            end else begin
                wen <= 1'b0;
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        w_pend = '0;
        w_off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = AW'(i) - r_rp;
            if (({1'b0, w_off} < r_count) && (r_mem_rd[i] != 5'd0))
                w_pend[r_mem_rd[i]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_wb_arbiter;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_data = '0;
    logic        ld_ready;
    logic        wen;
    logic [4:0]  regWAddr;
    logic [31:0] regWData;
    logic [31:0] pend_mask;
    logic [2:0]  buf_count;

    int n_chk  = 0;
    int n_fail = 0;

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .wen(wen), .regWAddr(regWAddr), .regWData(regWData),
        .pend_mask(pend_mask), .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    // Reference model: pending loads in a queue, write port as three plain variables.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          m_starve;
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic m_clear();
        q.delete();
        m_starve = 0;
        m_wen    = 1'b0;
        m_addr   = '0;
        m_data   = '0;
    endtask

    task automatic m_step();
        ent_t e, n;
        bit   have, alu_pick, take_ld, force_ld;
        int   sz;
        sz       = q.size();
        force_ld = (m_starve == STARVE_MAX) && (sz > 0);
        take_ld  = ld_valid && (sz < DEPTH);
        have     = 0;
        alu_pick = 0;
        e.rd     = '0;
        e.data   = '0;
        if (force_ld || (!alu_valid && sz > 0)) begin
            e    = q.pop_front();
            have = 1;
        end else if (alu_valid) begin
            e.rd     = alu_rd;
            e.data   = alu_data;
            have     = 1;
            alu_pick = 1;
        end
        if (alu_pick && sz > 0)
            m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
        else
            m_starve = 0;
        if (have && e.rd != 5'd0) begin
            m_wen  = 1'b1;
            m_addr = e.rd;
            m_data = e.data;
        end else begin
            m_wen = 1'b0;
        end
        if (take_ld) begin
            n.rd   = ld_rd;
            n.data = ld_data;
            q.push_back(n);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clk);
            if (!reset) m_clear();
            else        m_step();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        logic [31:0] ep;
        forever begin
            @(negedge clk);
            ep = '0;
            foreach (q[i]) if (q[i].rd != 5'd0) ep[q[i].rd] = 1'b1;
            chk("cyc_wen",   32'(wen),       32'(m_wen));
            chk("cyc_addr",  32'(regWAddr),  32'(m_addr));
            chk("cyc_data",  regWData,       m_data);
            chk("cyc_count", 32'(buf_count), 32'(q.size()));
            chk("cyc_ldrdy", 32'(ld_ready),  32'(q.size() != DEPTH));
            chk("cyc_alurdy", 32'(alu_ready),
                32'(!((m_starve == STARVE_MAX) && q.size() > 0)));
            chk("cyc_pend",  pend_mask,      ep);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wen",    32'(wen), 0);
        chk("rst_addr",   32'(regWAddr), 0);
        chk("rst_data",   regWData, 0);
        chk("rst_count",  32'(buf_count), 0);
        chk("rst_pend",   pend_mask, 0);
        chk("rst_ldrdy",  32'(ld_ready), 1);
        chk("rst_alurdy", 32'(alu_ready), 1);
        reset = 1'b1;

        // ALU-only; also the first edge after reset release
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        tick();
        chk("alu_wen",   32'(wen), 1);
        chk("alu_addr",  32'(regWAddr), 5);
        chk("alu_data",  regWData, 32'h1234);
        chk("alu_ldrdy", 32'(ld_ready), 1);

        // Load buffering under continuous ALU traffic
        alu_rd = 9;
        for (int i = 1; i <= 4; i++) begin
            ld_valid = 1; ld_rd = 5'(i); ld_data = 32'h100 + 32'(i); alu_data = 32'(i);
            tick();
        end
        ld_valid = 0;
        chk("buf_count4", 32'(buf_count), 4);
        chk("buf_ldrdy0", 32'(ld_ready), 0);
        chk("buf_pend",   pend_mask, 32'h1E);
        chk("buf_alurdy", 32'(alu_ready), 1);
        tick();
        chk("force_alurdy0", 32'(alu_ready), 0);
        tick();
        chk("force_wen",     32'(wen), 1);
        chk("force_addr",    32'(regWAddr), 1);
        chk("force_data",    regWData, 32'h101);
        chk("force_alurdy1", 32'(alu_ready), 1);
        chk("force_count",   32'(buf_count), 3);
        alu_valid = 0;
        repeat (3) tick();
        chk("drain4_count", 32'(buf_count), 0);
        chk("drain4_addr",  32'(regWAddr), 4);

        // Drain order for two loads to the same register
        alu_valid = 1; alu_rd = 9; alu_data = 32'h55;
        ld_valid = 1; ld_rd = 7; ld_data = 32'hA;
        tick();
        ld_data = 32'hB;
        tick();
        alu_valid = 0; ld_valid = 0;
        chk("ord_count", 32'(buf_count), 2);
        chk("ord_pend0", pend_mask, 32'h80);
        tick();
        chk("ord_wenA",  32'(wen), 1);
        chk("ord_dataA", regWData, 32'hA);
        chk("ord_pend1", pend_mask, 32'h80);
        tick();
        chk("ord_wenB",  32'(wen), 1);
        chk("ord_dataB", regWData, 32'hB);
        chk("ord_pend2", pend_mask, 0);
        tick();
        chk("ord_idle",  32'(wen), 0);

        // x0 suppression
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF_FFFF;
        chk("x0_alurdy", 32'(alu_ready), 1);
        tick();
        alu_valid = 0;
        chk("x0_wen",   32'(wen), 0);
        chk("x0_addr",  32'(regWAddr), 7);
        chk("x0_data",  regWData, 32'hB);
        chk("x0_count", 32'(buf_count), 0);

        // Simultaneous enqueue and dequeue
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        ld_valid = 1; ld_rd = 3; ld_data = 32'h31;
        tick();
        ld_rd = 4; ld_data = 32'h41;
        tick();
        alu_valid = 0; ld_rd = 5; ld_data = 32'h51;
        chk("sim_count0", 32'(buf_count), 2);
        tick();
        ld_valid = 0;
        chk("sim_count1", 32'(buf_count), 2);
        chk("sim_addr3",  32'(regWAddr), 3);
        chk("sim_data3",  regWData, 32'h31);
        tick();
        chk("sim_addr4",  32'(regWAddr), 4);
        chk("sim_data4",  regWData, 32'h41);
        tick();
        chk("sim_addr5",  32'(regWAddr), 5);
        chk("sim_data5",  regWData, 32'h51);
        chk("sim_count3", 32'(buf_count), 0);

        // Asynchronous reset with three buffered loads
        alu_valid = 1; alu_rd = 9; alu_data = 32'h77;
        ld_valid = 1;
        for (int i = 0; i < 3; i++) begin
            ld_rd = 5'(10 + i); ld_data = 32'h200 + 32'(i);
            tick();
        end
        ld_valid = 0;
        chk("ar_count3", 32'(buf_count), 3);
        chk("ar_wen1",   32'(wen), 1);
        #2;
        reset = 1'b0;
        m_clear();
        #1;
        chk("ar_wen",    32'(wen), 0);
        chk("ar_addr",   32'(regWAddr), 0);
        chk("ar_data",   regWData, 0);
        chk("ar_count",  32'(buf_count), 0);
        chk("ar_pend",   pend_mask, 0);
        chk("ar_ldrdy",  32'(ld_ready), 1);
        alu_valid = 0;
        repeat (2) tick();
        chk("ar_hold_wen", 32'(wen), 0);
        reset = 1'b1;
        tick();
        chk("ar_rel_wen",   32'(wen), 0);
        chk("ar_rel_count", 32'(buf_count), 0);

        // Randomized traffic, biased toward ALU pressure and few register numbers
        for (int it = 0; it < 3000; it++) begin
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_data  = $urandom();
            ld_valid  = ($urandom_range(0, 1) != 0);
            ld_rd     = 5'($urandom_range(0, 7));
            ld_data   = $urandom();
            if (it % 400 == 399) begin
                alu_valid = 0;
                ld_valid  = 0;
                repeat (5) tick();
            end
            tick();
        end
        alu_valid = 0; ld_valid = 0;
        repeat (DEPTH + 2) tick();
        chk("end_count", 32'(buf_count), 0);
        chk("end_wen",   32'(wen), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
